avg_encode: RTL and testbench

Command-to-instruction encoder for the AVG vector generator, the write-side counterpart of the instruction decoder. It accepts one display command per handshake and serializes the encoded AVG instruction as bytes into vector RAM. Bytes are written little-endian per 16-bit word at an auto-incrementing pointer, so the decoder reads back exactly the command that was issued. It sits between the 6502-side display-list builder (or a test sequencer) and the vector RAM write port.

---
 rtl/avg_encode.sv | 186 ++++++++++++++++++
 tb/tb_avg_encode.sv | 243 ++++++++++++++++++++++++
 2 files changed

// File: rtl/avg_encode.sv
// rtl/avg_encode.sv - AVG command-to-instruction encoder writing vector RAM bytes
// Optional feature macro: AVG_ENC_SVEC_AUTO_EN (VCTR auto-shortened to SVEC when it fits)

`ifndef OP_VCTR
`define OP_VCTR  3'b000
`define OP_HALT  3'b001
`define OP_SVEC  3'b010
`define OP_STORE 3'b011
`define OP_CNTR  3'b100
`define OP_JSR   3'b101
`define OP_RTS   3'b110
`define OP_JMP   3'b111
`endif

module avg_encode #(
  parameter int ADDR_W = 13
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              base_load,
  input  logic [ADDR_W-1:0] base_addr,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic [3:0]        cmd_kind,
  input  logic [12:0]       cmd_dx,
  input  logic [12:0]       cmd_dy,
  input  logic [7:0]        cmd_z,
  input  logic [2:0]        cmd_color,
  input  logic [7:0]        cmd_lin,
  input  logic [2:0]        cmd_bin,
  input  logic [15:0]       cmd_target,
  output logic              vram_we,
  output logic [ADDR_W-1:0] vram_addr,
  output logic [7:0]        vram_wdata,
  input  logic              vram_gnt,
  output logic [ADDR_W-1:0] wr_ptr,
  output logic              done,
  output logic              err
);

  typedef enum logic {IDLE, EMIT} state_t;

  state_t          state;
  logic [1:0]      idx;
  logic [2:0]      len;
  logic [3:0][7:0] bytes_q;

  // combinational encoding of the command currently on the inputs
  logic [3:0][7:0] enc;
  logic [2:0]      enc_len;
  logic            enc_ok;
  logic            svec_ok;
  logic            tgt_ok;
  logic [7:0]      svec_b0, svec_b1;
  logic [3:0][7:0] vctr_b;
  logic [ADDR_W:0] end_sum;
  logic [ADDR_W:0] mem_size;

  // short vectors need even deltas that sign-extend from bit 5
  assign svec_ok = !cmd_dx[0] && !cmd_dy[0] &&
                   ((&cmd_dx[12:5]) || !(|cmd_dx[12:5])) &&
                   ((&cmd_dy[12:5]) || !(|cmd_dy[12:5]));
  assign tgt_ok  = !cmd_target[0] && (cmd_target[15:13] == 3'b000);

  assign svec_b0 = {cmd_z[2:0], cmd_dx[5:1]};
  assign svec_b1 = {`OP_SVEC, cmd_dy[5:1]};
  assign vctr_b  = {{cmd_z[2:0], cmd_dx[12:8]}, cmd_dx[7:0],
                    {`OP_VCTR, cmd_dy[12:8]}, cmd_dy[7:0]};

  assign end_sum  = {1'b0, wr_ptr} + {{(ADDR_W-2){1'b0}}, enc_len};
  assign mem_size = {1'b1, {ADDR_W{1'b0}}};

  // select byte image, length and legality from the command kind
  always_comb begin
    enc     = '0;
    enc_len = 3'd2;
    enc_ok  = 1'b1;
    case (cmd_kind)
      4'd0: begin
`ifdef AVG_ENC_SVEC_AUTO_EN
        if (svec_ok) begin
          enc[0] = svec_b0;
          enc[1] = svec_b1;
        end else begin
          enc     = vctr_b;
          enc_len = 3'd4;
        end
`else
        enc     = vctr_b;
        enc_len = 3'd4;
`endif
      end
      4'd1: begin
        enc[0] = svec_b0;
        enc[1] = svec_b1;
        enc_ok = svec_ok;
      end
      4'd2: enc[1] = {`OP_HALT, 5'b0};
      4'd3: begin
        enc[0] = cmd_z;
        enc[1] = {`OP_STORE, 2'b00, cmd_color};
      end
      4'd4: begin
        enc[0] = cmd_lin;
        enc[1] = {`OP_STORE, 2'b10, cmd_bin};
      end
      4'd5: enc[1] = {`OP_CNTR, 5'b0};
      4'd6: begin
        enc[0] = cmd_target[8:1];
        enc[1] = {`OP_JSR, 1'b0, cmd_target[12:9]};
        enc_ok = tgt_ok;
      end
      4'd7: begin
        enc[0] = cmd_target[8:1];
        enc[1] = {`OP_JMP, 1'b0, cmd_target[12:9]};
        enc_ok = tgt_ok;
      end
      4'd8: enc[1] = {`OP_RTS, 5'b0};
      default: enc_ok = 1'b0;
    endcase
    // the write must not run past the top of vector RAM
    if (end_sum > mem_size) enc_ok = 1'b0;
  end

  logic [1:0] idx_nxt;
  logic       last;
  assign idx_nxt = idx + 2'd1;
  assign last    = ({1'b0, idx} == (len - 3'd1));

  // command FSM: latch on handshake, then emit bytes one grant at a time
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      idx        <= '0;
      len        <= '0;
      bytes_q    <= '0;
      cmd_ready  <= 1'b1;
      vram_we    <= 1'b0;
      vram_addr  <= '0;
      vram_wdata <= '0;
      wr_ptr     <= '0;
      done       <= 1'b0;
      err        <= 1'b0;
    end else begin
      done <= 1'b0;
      err  <= 1'b0;
      case (state)
        IDLE: begin
          if (cmd_valid) begin
            if (enc_ok) begin
              state      <= EMIT;
              cmd_ready  <= 1'b0;
              bytes_q    <= enc;
              len        <= enc_len;
              idx        <= '0;
              vram_we    <= 1'b1;
              vram_addr  <= wr_ptr;
              vram_wdata <= enc[0];
            end else begin
              err <= 1'b1;
            end
          end
          // a load in the same cycle as a handshake wins for the pointer
          if (base_load) wr_ptr <= base_addr;
        end
        EMIT: begin
          if (vram_gnt) begin
            if (last) begin
              state     <= IDLE;
              cmd_ready <= 1'b1;
              vram_we   <= 1'b0;
              wr_ptr    <= wr_ptr + {{(ADDR_W-3){1'b0}}, len};
              done      <= 1'b1;
            end else begin
              idx        <= idx_nxt;
              vram_addr  <= wr_ptr + {{(ADDR_W-2){1'b0}}, idx_nxt};
              vram_wdata <= bytes_q[idx_nxt];
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_avg_encode.sv
// tb/tb_avg_encode.sv - scoreboard bench for avg_encode with directed vectors

module tb_avg_encode;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        base_load = 1'b0;
  logic [12:0] base_addr = '0;
  logic        cmd_valid = 1'b0;
  logic        cmd_ready;
  logic [3:0]  cmd_kind = '0;
  logic [12:0] cmd_dx = '0, cmd_dy = '0;
  logic [7:0]  cmd_z = '0;
  logic [2:0]  cmd_color = '0;
  logic [7:0]  cmd_lin = '0;
  logic [2:0]  cmd_bin = '0;
  logic [15:0] cmd_target = '0;
  logic        vram_we;
  logic [12:0] vram_addr;
  logic [7:0]  vram_wdata;
  logic        vram_gnt = 1'b1;
  logic [12:0] wr_ptr;
  logic        done, err;

  avg_encode #(.ADDR_W(13)) dut (
    .clk(clk), .rst(rst), .base_load(base_load), .base_addr(base_addr),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_kind(cmd_kind),
    .cmd_dx(cmd_dx), .cmd_dy(cmd_dy), .cmd_z(cmd_z), .cmd_color(cmd_color),
    .cmd_lin(cmd_lin), .cmd_bin(cmd_bin), .cmd_target(cmd_target),
    .vram_we(vram_we), .vram_addr(vram_addr), .vram_wdata(vram_wdata),
    .vram_gnt(vram_gnt), .wr_ptr(wr_ptr), .done(done), .err(err)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int vectors = 0;
  int miscompares = 0;
  int done_cnt = 0, err_cnt = 0, grant_cnt = 0;
  int done_cyc = 0, err_cyc = 0;
  logic [20:0] exp_q[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic push(input logic [12:0] a, input logic [7:0] d);
    exp_q.push_back({a, d});
  endtask

  // monitor: pops the scoreboard on every granted write, counts pulses
  task automatic monitor_loop();
    logic [20:0] e;
    forever begin
      @(negedge clk);
      if (done) begin done_cnt++; done_cyc = cyc; end
      if (err)  begin err_cnt++;  err_cyc  = cyc; end
      if (vram_we && vram_gnt) begin
        grant_cnt++;
        if (exp_q.size() == 0) begin
          vectors++;
          miscompares++;
          $display("FAIL unexpected write: addr %0h data %0h, none expected", vram_addr, vram_wdata);
        end else begin
          e = exp_q.pop_front();
          chk("write addr", {19'b0, vram_addr}, {19'b0, e[20:8]});
          chk("write data", {24'b0, vram_wdata}, {24'b0, e[7:0]});
        end
      end
    end
  endtask

  task automatic check_reset_vals(input string tag);
    chk({tag, " cmd_ready"}, {31'b0, cmd_ready}, 32'd1);
    chk({tag, " vram_we"}, {31'b0, vram_we}, 32'd0);
    chk({tag, " vram_addr"}, {19'b0, vram_addr}, 32'd0);
    chk({tag, " vram_wdata"}, {24'b0, vram_wdata}, 32'd0);
    chk({tag, " wr_ptr"}, {19'b0, wr_ptr}, 32'd0);
    chk({tag, " done"}, {31'b0, done}, 32'd0);
    chk({tag, " err"}, {31'b0, err}, 32'd0);
  endtask

  task automatic load_base(input logic [12:0] a);
    @(posedge clk); #1;
    base_load = 1'b1;
    base_addr = a;
    @(posedge clk); #1;
    base_load = 1'b0;
  endtask

  task automatic run_cmd(input logic [3:0] kind, input logic [12:0] dx, input logic [12:0] dy,
                         input logic [7:0] z, input logic [2:0] color, input logic [7:0] lin,
                         input logic [2:0] bin, input logic [15:0] target, input bit exp_err,
                         input int exp_len, input bit rnd, input int stop_after);
    int d0, e0, g0, hs;
    bit reached;
    d0 = done_cnt; e0 = err_cnt; g0 = grant_cnt;
    @(posedge clk); #1;
    chk("cmd_ready before issue", {31'b0, cmd_ready}, 32'd1);
    cmd_kind = kind; cmd_dx = dx; cmd_dy = dy; cmd_z = z; cmd_color = color;
    cmd_lin = lin; cmd_bin = bin; cmd_target = target;
    cmd_valid = 1'b1;
    vram_gnt = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
    @(posedge clk); #1;
    hs = cyc;
    cmd_valid = 1'b0;
    reached = 1'b0;
    for (int i = 0; i < 300 && !reached; i++) begin
      if (stop_after > 0) begin
        if (grant_cnt - g0 >= stop_after) begin
          rst = 1'b1;
          vram_gnt = 1'b0;
          reached = 1'b1;
        end
      end else if (done_cnt != d0 || err_cnt != e0) begin
        reached = 1'b1;
      end
      if (!reached) begin
        if (rnd) vram_gnt = 1'($urandom_range(0, 1));
        @(posedge clk); #1;
      end
    end
    if (!reached) begin
      vectors++;
      miscompares++;
      $display("FAIL command timeout: kind %0d never finished within bound", kind);
    end
    if (stop_after == 0) begin
      repeat (2) @(posedge clk);
      #1;
      vram_gnt = 1'b1;
      chk("err pulses", done_cnt - d0 + 0 == 0 ? err_cnt - e0 : err_cnt - e0, exp_err ? 32'd1 : 32'd0);
      chk("done pulses", done_cnt - d0, exp_err ? 32'd0 : 32'd1);
      if (!rnd) begin
        if (exp_err) chk("err latency", err_cyc - hs, 32'd0);
        else         chk("done latency", done_cyc - hs, exp_len);
      end
    end
  endtask

`ifdef AVG_ENC_SVEC_AUTO_EN
  localparam bit AUTO = 1'b1;
`else
  localparam bit AUTO = 1'b0;
`endif

  initial begin
    fork
      monitor_loop();
    join_none

    repeat (3) @(posedge clk);
    @(negedge clk);
    check_reset_vals("reset");
    @(posedge clk); #1;
    rst = 1'b0;

    // VCTR at 0x100
    load_base(13'h100);
    chk("base load wr_ptr", {19'b0, wr_ptr}, 32'h100);
    push(13'h100, 8'h00); push(13'h101, 8'h1F); push(13'h102, 8'h23); push(13'h103, 8'hA1);
    run_cmd(4'd0, 13'h0123, 13'h1F00, 8'd5, 3'd0, 8'd0, 3'd0, 16'd0, 1'b0, 4, 1'b0, 0);
    chk("wr_ptr after vctr", {19'b0, wr_ptr}, 32'h104);

    // SVEC dx=4 dy=-2 z=7
    push(13'h104, 8'hE2); push(13'h105, 8'h5F);
    run_cmd(4'd1, 13'h0004, 13'h1FFE, 8'd7, 3'd0, 8'd0, 3'd0, 16'd0, 1'b0, 2, 1'b0, 0);
    chk("wr_ptr after svec", {19'b0, wr_ptr}, 32'h106);

    // same deltas issued as VCTR
    if (AUTO) begin
      push(13'h106, 8'hE2); push(13'h107, 8'h5F);
    end else begin
      push(13'h106, 8'hFE); push(13'h107, 8'h1F); push(13'h108, 8'h04); push(13'h109, 8'hE0);
    end
    run_cmd(4'd0, 13'h0004, 13'h1FFE, 8'd7, 3'd0, 8'd0, 3'd0, 16'd0, 1'b0, AUTO ? 2 : 4, 1'b0, 0);
    chk("wr_ptr after short vctr", {19'b0, wr_ptr}, AUTO ? 32'h108 : 32'h10A);

    // JMP, SCAL, STAT at 0x200
    load_base(13'h200);
    push(13'h200, 8'h23); push(13'h201, 8'hE1);
    run_cmd(4'd7, 13'd0, 13'd0, 8'd0, 3'd0, 8'd0, 3'd0, 16'h0246, 1'b0, 2, 1'b0, 0);
    push(13'h202, 8'h80); push(13'h203, 8'h72);
    run_cmd(4'd4, 13'd0, 13'd0, 8'd0, 3'd0, 8'h80, 3'd2, 16'd0, 1'b0, 2, 1'b0, 0);
    push(13'h204, 8'h3C); push(13'h205, 8'h66);
    run_cmd(4'd3, 13'd0, 13'd0, 8'h3C, 3'd6, 8'd0, 3'd0, 16'd0, 1'b0, 2, 1'b0, 0);
    chk("wr_ptr after stat", {19'b0, wr_ptr}, 32'h206);

    // rejections: odd JSR target, odd SVEC dx, out-of-range SVEC, target bit 13, illegal kind
    run_cmd(4'd6, 13'd0, 13'd0, 8'd0, 3'd0, 8'd0, 3'd0, 16'h0247, 1'b1, 0, 1'b0, 0);
    run_cmd(4'd1, 13'h0003, 13'h0000, 8'd1, 3'd0, 8'd0, 3'd0, 16'd0, 1'b1, 0, 1'b0, 0);
    run_cmd(4'd1, 13'h0020, 13'h0000, 8'd1, 3'd0, 8'd0, 3'd0, 16'd0, 1'b1, 0, 1'b0, 0);
    run_cmd(4'd7, 13'd0, 13'd0, 8'd0, 3'd0, 8'd0, 3'd0, 16'h2000, 1'b1, 0, 1'b0, 0);
    run_cmd(4'd9, 13'd0, 13'd0, 8'd0, 3'd0, 8'd0, 3'd0, 16'd0, 1'b1, 0, 1'b0, 0);
    chk("wr_ptr after rejects", {19'b0, wr_ptr}, 32'h206);

    // SVEC range edges dx=-32 dy=30
    push(13'h206, 8'h10); push(13'h207, 8'h4F);
    run_cmd(4'd1, 13'h1FE0, 13'h001E, 8'd0, 3'd0, 8'd0, 3'd0, 16'd0, 1'b0, 2, 1'b0, 0);
    chk("wr_ptr after svec edge", {19'b0, wr_ptr}, 32'h208);

    // top of memory: VCTR rejected, HALT fits and wraps pointer
    load_base(13'h1FFE);
    run_cmd(4'd0, 13'h0123, 13'h1F00, 8'd5, 3'd0, 8'd0, 3'd0, 16'd0, 1'b1, 0, 1'b0, 0);
    chk("wr_ptr after overflow reject", {19'b0, wr_ptr}, 32'h1FFE);
    push(13'h1FFE, 8'h00); push(13'h1FFF, 8'h20);
    run_cmd(4'd2, 13'd0, 13'd0, 8'd0, 3'd0, 8'd0, 3'd0, 16'd0, 1'b0, 2, 1'b0, 0);
    chk("wr_ptr after halt wrap", {19'b0, wr_ptr}, 32'h0);

    // random grant VCTR, then CNTR and RTS
    load_base(13'h040);
    push(13'h040, 8'h55); push(13'h041, 8'h01); push(13'h042, 8'hBC); push(13'h043, 8'h4A);
    run_cmd(4'd0, 13'h0ABC, 13'h0155, 8'd2, 3'd0, 8'd0, 3'd0, 16'd0, 1'b0, 4, 1'b1, 0);
    chk("wr_ptr after stalled vctr", {19'b0, wr_ptr}, 32'h044);
    push(13'h044, 8'h00); push(13'h045, 8'h80);
    run_cmd(4'd5, 13'd0, 13'd0, 8'd0, 3'd0, 8'd0, 3'd0, 16'd0, 1'b0, 2, 1'b1, 0);
    push(13'h046, 8'h00); push(13'h047, 8'hC0);
    run_cmd(4'd8, 13'd0, 13'd0, 8'd0, 3'd0, 8'd0, 3'd0, 16'd0, 1'b0, 2, 1'b0, 0);
    chk("wr_ptr after rts", {19'b0, wr_ptr}, 32'h048);

    // reset after two bytes of a stalled VCTR
    push(13'h048, 8'h77); push(13'h049, 8'h07);
    run_cmd(4'd0, 13'h1001, 13'h0777, 8'd3, 3'd0, 8'd0, 3'd0, 16'd0, 1'b0, 4, 1'b1, 2);
    @(posedge clk);
    @(negedge clk);
    check_reset_vals("mid-emit reset");
    @(posedge clk); #1;
    rst = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("scoreboard drained", exp_q.size(), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
